// File: rtl/simon_sequencer.sv
// -----------------------------------------------------------------------------
// simon_sequencer
// Game sequencer for a four-square "Simon" memory game. Each round appends one
// pseudo-random step to the sequence and replays the whole sequence through a
// request/done handshake to an external square drawer. Each step is shown as a
// highlight, an on-time, a repaint back to normal and an off-time. The player
// then repeats the sequence with click pulses. Reaching MAX_LEN steps wins, and
// any wrong click loses.
//
// Ports
//   clock_i        sole clock, rising edge
//   reset_n_i      synchronous active-low reset
//   start_i        one-cycle pulse, starts a new game (IDLE/WIN/LOSE only)
//   clicked_i      one-cycle pulse, player press (WAIT_INPUT only)
//   direction_i    pressed square: 0 up, 1 down, 2 right, 3 left
//   draw_req_o     registered request to the square drawer
//   draw_dir_o     square to repaint, held stable while draw_req_o is high
//   draw_color_o   3'b010 highlight, 3'b111 normal
//   draw_done_i    one-cycle pulse from the drawer, request complete
//   level_o        current sequence length
//   busy_o         high outside IDLE/WIN/LOSE
//   win_o          high only in WIN
//   game_over_o    high only in LOSE
// -----------------------------------------------------------------------------
module simon_sequencer #(
    parameter int unsigned MAX_LEN   = 16,
    parameter int unsigned ON_TICKS  = 25000000,
    parameter int unsigned OFF_TICKS = 12500000,
    parameter logic [15:0] SEED      = 16'hACE1
) (
    input  logic       clock_i,
    input  logic       reset_n_i,
    input  logic       start_i,
    input  logic       clicked_i,
    input  logic [1:0] direction_i,
    output logic       draw_req_o,
    output logic [1:0] draw_dir_o,
    output logic [2:0] draw_color_o,
    input  logic       draw_done_i,
    output logic [4:0] level_o,
    output logic       busy_o,
    output logic       win_o,
    output logic       game_over_o
);

    // The timer only ever holds 0 .. max(ON,OFF)-1, so it can never wrap
    // before reaching its terminal count.
    localparam int unsigned TICK_MAX = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
    localparam int unsigned TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam logic [TW-1:0] ON_LAST  = TW'(ON_TICKS - 1);
    localparam logic [TW-1:0] OFF_LAST = TW'(OFF_TICKS - 1);
    localparam logic [4:0]    LEN_MAX  = 5'(MAX_LEN);
    localparam logic [2:0]    COLOR_HI   = 3'b010;
    localparam logic [2:0]    COLOR_NORM = 3'b111;

    typedef enum logic [3:0] {
        S_IDLE       = 4'd0,
        S_ADD_STEP   = 4'd1,
        S_PLAY_HI    = 4'd2,
        S_PLAY_ON    = 4'd3,
        S_PLAY_LO    = 4'd4,
        S_PLAY_OFF   = 4'd5,
        S_WAIT_INPUT = 4'd6,
        S_WIN        = 4'd7,
        S_LOSE       = 4'd8
    } state_e;

    // Fibonacci LFSR, taps 16,14,13,11 (right-shifting form).
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return {v[0] ^ v[2] ^ v[3] ^ v[5], v[15:1]};
    endfunction

    // Mux one 2-bit step out of the packed sequence store.
    function automatic logic [1:0] seq_pick(input logic [2*MAX_LEN-1:0] v,
                                            input logic [4:0] idx);
        logic [1:0] r;
        r = 2'b00;
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            r = (idx == 5'(i)) ? v[2*i +: 2] : r;
        end
        return r;
    endfunction

    state_e                 state_q, state_d;
    logic [15:0]            lfsr_q;
    logic [4:0]             level_q, level_d;
    logic [4:0]             idx_q, idx_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [2*MAX_LEN-1:0]   seq_q;
    logic                   seq_we_s;
    logic [1:0]             seq_cur_s;
    logic [1:0]             dir_next_s;
    logic                   play_s;
    logic                   draw_req_q;
    logic [1:0]             draw_dir_q;
    logic [2:0]             draw_color_q;
    logic                   busy_q, win_q, game_over_q;

    assign seq_cur_s = seq_pick(seq_q, idx_q);
    assign play_s    = (state_d == S_PLAY_HI) || (state_d == S_PLAY_LO);

    // The step written in ADD_STEP is not in seq_q yet when the first PLAY_HI
    // request is registered, so forward it straight from the LFSR.
    assign dir_next_s = (seq_we_s && (idx_d == level_q)) ? lfsr_q[1:0]
                                                          : seq_pick(seq_q, idx_d);

    // Next-state, counter and sequence-write decode.
    always_comb begin
        state_d  = state_q;
        level_d  = level_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        seq_we_s = 1'b0;
        case (state_q)
            S_IDLE, S_WIN, S_LOSE: begin
                if (start_i) begin
                    state_d = S_ADD_STEP;
                    level_d = 5'd0;
                    idx_d   = 5'd0;
                end else begin
                    state_d = state_q;
                end
            end
            S_ADD_STEP: begin
                seq_we_s = 1'b1;
                level_d  = level_q + 5'd1;
                idx_d    = 5'd0;
                state_d  = S_PLAY_HI;
            end
            S_PLAY_HI, S_PLAY_LO: begin
                if (draw_req_q && draw_done_i) begin
                    state_d = (state_q == S_PLAY_HI) ? S_PLAY_ON : S_PLAY_OFF;
                    timer_d = '0;
                end else begin
                    state_d = state_q;
                end
            end
            S_PLAY_ON: begin
                if (timer_q == ON_LAST) begin
                    state_d = S_PLAY_LO;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_PLAY_OFF: begin
                if (timer_q != OFF_LAST) begin
                    timer_d = timer_q + 1'b1;
                end else if (idx_q == level_q - 5'd1) begin
                    state_d = S_WAIT_INPUT;
                    idx_d   = 5'd0;
                end else begin
                    state_d = S_PLAY_HI;
                    idx_d   = idx_q + 5'd1;
                end
            end
            S_WAIT_INPUT: begin
                if (!clicked_i) begin
                    state_d = state_q;
                end else if (direction_i != seq_cur_s) begin
                    state_d = S_LOSE;
                end else if (idx_q != level_q - 5'd1) begin
                    idx_d = idx_q + 5'd1;
                end else begin
                    state_d = (level_q == LEN_MAX) ? S_WIN : S_ADD_STEP;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, LFSR, counters and registered outputs.
    always_ff @(posedge clock_i) begin
        if (!reset_n_i) begin
            state_q      <= S_IDLE;
            lfsr_q       <= SEED;
            level_q      <= 5'd0;
            idx_q        <= 5'd0;
            timer_q      <= '0;
            draw_req_q   <= 1'b0;
            draw_dir_q   <= 2'd0;
            draw_color_q <= COLOR_NORM;
            busy_q       <= 1'b0;
            win_q        <= 1'b0;
            game_over_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_next(lfsr_q);
            level_q     <= level_d;
            idx_q       <= idx_d;
            timer_q     <= timer_d;
            draw_req_q  <= play_s;
            if (play_s) begin
                draw_dir_q   <= dir_next_s;
                draw_color_q <= (state_d == S_PLAY_HI) ? COLOR_HI : COLOR_NORM;
            end
            busy_q      <= !((state_d == S_IDLE) || (state_d == S_WIN) || (state_d == S_LOSE));
            win_q       <= (state_d == S_WIN);
            game_over_q <= (state_d == S_LOSE);
        end
    end

    // Sequence store; never read beyond level, so it carries no reset.
    always_ff @(posedge clock_i) begin
        for (int i = 0; i < int'(MAX_LEN); i++) begin
            if (seq_we_s && (level_q == 5'(i))) begin
                seq_q[2*i +: 2] <= lfsr_q[1:0];
            end
        end
    end

    assign draw_req_o   = draw_req_q;
    assign draw_dir_o   = draw_dir_q;
    assign draw_color_o = draw_color_q;
    assign level_o      = level_q;
    assign busy_o       = busy_q;
    assign win_o        = win_q;
    assign game_over_o  = game_over_q;

endmodule

// File: tb/tb_simon_sequencer.sv
// -----------------------------------------------------------------------------
// tb_simon_sequencer
// Directed bench for simon_sequencer with MAX_LEN=3, ON_TICKS=2, OFF_TICKS=1.
// The bench acts as the square drawer and the player. Expected step values come
// from a reference LFSR kept in step with the reset and clock seen by the DUT.
// -----------------------------------------------------------------------------
module tb_simon_sequencer;
    localparam int MAX_LEN   = 3;
    localparam int ON_TICKS  = 2;
    localparam int OFF_TICKS = 1;

    logic       clock     = 1'b0;
    logic       reset_n   = 1'b0;
    logic       start     = 1'b0;
    logic       clicked   = 1'b0;
    logic [1:0] direction = 2'd0;
    logic       draw_done = 1'b0;
    logic       draw_req;
    logic [1:0] draw_dir;
    logic [2:0] draw_color;
    logic [4:0] level;
    logic       busy, win, game_over;

    int total = 0;
    int bad   = 0;
    logic [15:0] m_lfsr, m_prev;
    logic [1:0]  exp_seq [0:MAX_LEN-1];

    simon_sequencer #(
        .MAX_LEN(MAX_LEN), .ON_TICKS(ON_TICKS), .OFF_TICKS(OFF_TICKS), .SEED(16'hACE1)
    ) dut (
        .clock_i(clock), .reset_n_i(reset_n), .start_i(start), .clicked_i(clicked),
        .direction_i(direction), .draw_req_o(draw_req), .draw_dir_o(draw_dir),
        .draw_color_o(draw_color), .draw_done_i(draw_done), .level_o(level),
        .busy_o(busy), .win_o(win), .game_over_o(game_over)
    );

    always #5 clock = ~clock;

    // Reference LFSR; m_prev is the value held during the previous cycle.
    always @(posedge clock) begin
        m_prev <= m_lfsr;
        if (!reset_n) m_lfsr <= 16'hACE1;
        else          m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end

    task automatic wait_req(output int gap);
        gap = 0;
        while (draw_req !== 1'b1 && gap < 100) begin
            gap++;
            @(negedge clock);
        end
        if (draw_req !== 1'b1) gap = -1;
    endtask

    task automatic pulse_done();
        draw_done = 1'b1;
        @(negedge clock);
        draw_done = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic do_click(input logic [1:0] d, input logic with_start);
        clicked = 1'b1; direction = d; start = with_start;
        @(negedge clock);
        clicked = 1'b0; start = 1'b0;
    endtask

    // Serve one full replay of lvl steps and land in WAIT_INPUT.
    task automatic run_round(input int lvl, input int delay);
        int gap;
        logic [1:0] d0;
        for (int k = 0; k < lvl; k++) begin
            wait_req(gap);
            if (k == 0) begin
                exp_seq[lvl-1] = m_prev[1:0];
                total++; if (gap < 0) begin bad++; $display("FAIL hi_timeout got=%0d req>=0", gap); end
                total++; if (level !== 5'(lvl)) begin bad++; $display("FAIL round_level got=%0d exp=%0d", level, lvl); end
            end else begin
                total++; if (gap !== OFF_TICKS) begin bad++; $display("FAIL off_gap step=%0d got=%0d exp=%0d", k, gap, OFF_TICKS); end
            end
            total++; if (draw_color !== 3'b010) begin bad++; $display("FAIL hi_color got=%b exp=010", draw_color); end
            total++; if (draw_dir !== exp_seq[k]) begin bad++; $display("FAIL hi_dir lvl=%0d step=%0d got=%0d exp=%0d", lvl, k, draw_dir, exp_seq[k]); end
            d0 = draw_dir;
            for (int j = 0; j < delay; j++) begin
                @(negedge clock);
                total++; if (draw_req !== 1'b1 || draw_dir !== d0 || draw_color !== 3'b010) begin
                    bad++; $display("FAIL hold_hi req=%b dir=%0d col=%b exp 1/%0d/010", draw_req, draw_dir, draw_color, d0); end
            end
            pulse_done();
            total++; if (draw_req !== 1'b0) begin bad++; $display("FAIL hi_drop got=%b exp=0", draw_req); end
            wait_req(gap);
            total++; if (gap !== ON_TICKS) begin bad++; $display("FAIL on_gap got=%0d exp=%0d", gap, ON_TICKS); end
            total++; if (draw_color !== 3'b111 || draw_dir !== d0) begin
                bad++; $display("FAIL lo_req col=%b dir=%0d exp 111/%0d", draw_color, draw_dir, d0); end
            for (int j = 0; j < delay; j++) begin
                @(negedge clock);
                total++; if (draw_req !== 1'b1 || draw_dir !== d0 || draw_color !== 3'b111) begin
                    bad++; $display("FAIL hold_lo req=%b dir=%0d col=%b exp 1/%0d/111", draw_req, draw_dir, draw_color, d0); end
            end
            pulse_done();
            total++; if (draw_req !== 1'b0) begin bad++; $display("FAIL lo_drop got=%b exp=0", draw_req); end
        end
        @(negedge clock);
        total++; if (busy !== 1'b1 || draw_req !== 1'b0 || win !== 1'b0) begin
            bad++; $display("FAIL wait_state busy=%b req=%b win=%b exp 1/0/0", busy, draw_req, win); end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        total++; if (draw_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b exp=0", draw_req); end
        total++; if (draw_dir !== 2'd0) begin bad++; $display("FAIL rst_dir got=%0d exp=0", draw_dir); end
        total++; if (draw_color !== 3'b111) begin bad++; $display("FAIL rst_color got=%b exp=111", draw_color); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL rst_level got=%0d exp=0", level); end
        total++; if (busy !== 1'b0 || win !== 1'b0 || game_over !== 1'b0) begin
            bad++; $display("FAIL rst_flags busy=%b win=%b go=%b exp 0/0/0", busy, win, game_over); end
        reset_n = 1'b1;
        pulse_done();
        do_click(2'd1, 1'b0);
        total++; if (busy !== 1'b0 || draw_req !== 1'b0) begin
            bad++; $display("FAIL idle_ignore busy=%b req=%b exp 0/0", busy, draw_req); end
    endtask

    task automatic test_first_round();
        pulse_start();
        run_round(1, 0);
        total++; if (level !== 5'd1) begin bad++; $display("FAIL first_level got=%0d exp=1", level); end
    endtask

    task automatic test_win();
        for (int lvl = 2; lvl <= MAX_LEN + 1; lvl++) begin
            for (int k = 0; k < lvl - 2; k++) begin
                do_click(exp_seq[k], 1'b0);
                total++; if (busy !== 1'b1 || draw_req !== 1'b0 || level !== 5'(lvl - 1)) begin
                    bad++; $display("FAIL mid_click busy=%b req=%b lvl=%0d exp 1/0/%0d", busy, draw_req, level, lvl - 1); end
            end
            do_click(exp_seq[lvl-2], 1'b0);
            if (lvl <= MAX_LEN) run_round(lvl, 0);
        end
        total++; if (win !== 1'b1 || busy !== 1'b0 || game_over !== 1'b0 || level !== 5'd3) begin
            bad++; $display("FAIL win_state win=%b busy=%b go=%b lvl=%0d exp 1/0/0/3", win, busy, game_over, level); end
        do_click(exp_seq[0], 1'b0);
        total++; if (win !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL win_hold win=%b busy=%b exp 1/0", win, busy); end
    endtask

    task automatic test_lose();
        logic [1:0] wrong;
        pulse_start();
        run_round(1, 0);
        do_click(exp_seq[0], 1'b0);
        run_round(2, 0);
        wrong = exp_seq[0] + 2'd1;
        do_click(wrong, 1'b0);
        total++; if (game_over !== 1'b1 || busy !== 1'b0 || win !== 1'b0 || level !== 5'd2) begin
            bad++; $display("FAIL lose_state go=%b busy=%b win=%b lvl=%0d exp 1/0/0/2", game_over, busy, win, level); end
        do_click(exp_seq[0], 1'b0);
        do_click(exp_seq[1], 1'b0);
        total++; if (game_over !== 1'b1 || busy !== 1'b0 || level !== 5'd2) begin
            bad++; $display("FAIL lose_hold go=%b busy=%b lvl=%0d exp 1/0/2", game_over, busy, level); end
    endtask

    task automatic test_slow_drawer();
        pulse_start();
        run_round(1, 5);
        do_click(exp_seq[0], 1'b0);
    endtask

    task automatic test_reset_mid_play();
        int gap;
        wait_req(gap);
        exp_seq[1] = m_prev[1:0];
        total++; if (level !== 5'd2 || gap < 0) begin bad++; $display("FAIL pre_rst_level got=%0d exp=2", level); end
        pulse_done();
        reset_n = 1'b0;
        @(negedge clock);
        total++; if (draw_req !== 1'b0 || draw_dir !== 2'd0 || draw_color !== 3'b111) begin
            bad++; $display("FAIL mid_rst_draw req=%b dir=%0d col=%b exp 0/0/111", draw_req, draw_dir, draw_color); end
        total++; if (level !== 5'd0 || busy !== 1'b0 || win !== 1'b0 || game_over !== 1'b0) begin
            bad++; $display("FAIL mid_rst_state lvl=%0d busy=%b win=%b go=%b exp 0/0/0/0", level, busy, win, game_over); end
        reset_n = 1'b1;
        pulse_done();
        total++; if (draw_req !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL late_done req=%b busy=%b exp 0/0", draw_req, busy); end
        pulse_start();
        run_round(1, 0);
    endtask

    task automatic test_ignored_inputs();
        int gap;
        logic [1:0] wrong;
        do_click(exp_seq[0], 1'b0);
        wait_req(gap);
        exp_seq[1] = m_prev[1:0];
        wrong = exp_seq[0] ^ 2'd2;
        total++; if (level !== 5'd2 || gap < 0) begin bad++; $display("FAIL ign_level got=%0d exp=2", level); end
        clicked = 1'b1; direction = wrong; start = 1'b1;
        @(negedge clock);
        clicked = 1'b0; start = 1'b0;
        total++; if (draw_req !== 1'b1 || draw_dir !== exp_seq[0] || level !== 5'd2 || busy !== 1'b1 || game_over !== 1'b0) begin
            bad++; $display("FAIL ign_hi req=%b dir=%0d lvl=%0d busy=%b go=%b exp 1/%0d/2/1/0", draw_req, draw_dir, level, busy, game_over, exp_seq[0]); end
        pulse_done();
        wait_req(gap);
        total++; if (gap !== ON_TICKS) begin bad++; $display("FAIL ign_on_gap got=%0d exp=%0d", gap, ON_TICKS); end
        pulse_done();
        clicked = 1'b1; direction = wrong;
        @(negedge clock);
        clicked = 1'b0;
        total++; if (draw_req !== 1'b1 || draw_dir !== exp_seq[1] || draw_color !== 3'b010 || level !== 5'd2 || game_over !== 1'b0) begin
            bad++; $display("FAIL ign_off req=%b dir=%0d col=%b lvl=%0d exp 1/%0d/010/2", draw_req, draw_dir, draw_color, level, exp_seq[1]); end
        pulse_done();
        wait_req(gap);
        pulse_done();
        @(negedge clock);
        do_click(exp_seq[0], 1'b1);
        total++; if (level !== 5'd2 || busy !== 1'b1 || draw_req !== 1'b0 || win !== 1'b0) begin
            bad++; $display("FAIL click_wins lvl=%0d busy=%b req=%b exp 2/1/0", level, busy, draw_req); end
        do_click(exp_seq[1], 1'b0);
        wait_req(gap);
        total++; if (level !== 5'd3 || draw_dir !== exp_seq[0] || gap < 0) begin
            bad++; $display("FAIL next_round lvl=%0d dir=%0d exp 3/%0d", level, draw_dir, exp_seq[0]); end
    endtask

    initial begin
        test_reset();
        test_first_round();
        test_win();
        test_lose();
        test_slow_drawer();
        test_reset_mid_play();
        test_ignored_inputs();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
